// File: rtl/nibble_serial_adder_ctrl.sv
// Wide add/subtract done one nibble per clock through a single shared 4-bit
// ripple adder, with a start/busy/done handshake around each operation.

module sum4bit (
   input  logic [3:0] a_i,
   input  logic [3:0] b_i,
   input  logic       c_i,
   output logic [3:0] s_o,
   output logic       c_o
);
   logic c;

   always_comb begin
      c   = c_i;
      s_o = '0;
      for (int i = 0; i < 4; i++) begin
         s_o[i] = a_i[i] ^ b_i[i] ^ c;
         c      = (a_i[i] & b_i[i]) | (c & (a_i[i] ^ b_i[i]));
      end
      c_o = c;
   end
endmodule

module nibble_serial_adder_ctrl #(
   parameter int NIBBLES = 4
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 start_i,
   input  logic                 sub_i,
   input  logic [4*NIBBLES-1:0] a_i,
   input  logic [4*NIBBLES-1:0] b_i,
   input  logic                 c_in_i,
   output logic [4*NIBBLES-1:0] s_o,
   output logic                 c_out_o,
   output logic                 ovf_o,
   output logic                 busy_o,
   output logic                 done_o
);
   localparam int W  = 4 * NIBBLES;
   localparam int CW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
   localparam logic [CW-1:0] LAST = CW'(NIBBLES - 1);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [W-1:0]  a_q, a_d, b_q, b_d, s_q, s_d;
   logic          carry_q, carry_d, cout_q, cout_d, ovf_q, ovf_d;
   logic [3:0]    sum;
   logic          sum_c;

   sum4bit u_add (
      .a_i (a_q[3:0]),
      .b_i (b_q[3:0]),
      .c_i (carry_q),
      .s_o (sum),
      .c_o (sum_c)
   );

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         a_q     <= '0;
         b_q     <= '0;
         s_q     <= '0;
         carry_q <= 1'b0;
         cout_q  <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         a_q     <= a_d;
         b_q     <= b_d;
         s_q     <= s_d;
         carry_q <= carry_d;
         cout_q  <= cout_d;
         ovf_q   <= ovf_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      a_d     = a_q;
      b_d     = b_q;
      s_d     = s_q;
      carry_d = carry_q;
      cout_d  = cout_q;
      ovf_d   = ovf_q;
      unique case (state_q)
         IDLE: if (start_i) begin
            // Subtraction is a + ~b + ~borrow, so the adder never changes.
            a_d     = a_i;
            b_d     = sub_i ? ~b_i : b_i;
            carry_d = c_in_i ^ sub_i;
            s_d     = '0;
            cout_d  = 1'b0;
            ovf_d   = 1'b0;
            cnt_d   = '0;
            state_d = RUN;
         end
         RUN: begin
            s_d     = (s_q >> 4) | (W'(sum) << (W - 4));
            a_d     = a_q >> 4;
            b_d     = b_q >> 4;
            carry_d = sum_c;
            cnt_d   = cnt_q + 1'b1;
            if (cnt_q == LAST) begin
               state_d = DONE;
               cout_d  = sum_c;
               ovf_d   = (a_q[3] == b_q[3]) && (sum[3] != a_q[3]);
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   assign s_o     = s_q;
   assign c_out_o = cout_q;
   assign ovf_o   = ovf_q;
   assign busy_o  = (state_q != IDLE);
   assign done_o  = (state_q == DONE);
endmodule

// File: tb/tb_nibble_serial_adder_ctrl.sv
// Bench for the serial adder: a 4-nibble and a 1-nibble instance checked
// against a plain-integer arithmetic model.

module tb_nibble_serial_adder_ctrl;
   logic        clk = 1'b0;
   logic        rst, start4, start1, sub, c_in;
   logic [15:0] a, b;
   logic [15:0] s4;
   logic [3:0]  s1;
   logic        cout4, ovf4, busy4, done4, cout1, ovf1, busy1, done1;
   logic        sel;
   logic [15:0] o_s;
   logic        o_cout, o_ovf, o_busy, o_done;
   int          n_chk = 0, n_fail = 0;

   always #5 clk = ~clk;

   nibble_serial_adder_ctrl #(.NIBBLES(4)) dut4 (
      .clk_i(clk), .rst_i(rst), .start_i(start4), .sub_i(sub), .a_i(a), .b_i(b),
      .c_in_i(c_in), .s_o(s4), .c_out_o(cout4), .ovf_o(ovf4), .busy_o(busy4), .done_o(done4));

   nibble_serial_adder_ctrl #(.NIBBLES(1)) dut1 (
      .clk_i(clk), .rst_i(rst), .start_i(start1), .sub_i(sub), .a_i(a[3:0]), .b_i(b[3:0]),
      .c_in_i(c_in), .s_o(s1), .c_out_o(cout1), .ovf_o(ovf1), .busy_o(busy1), .done_o(done1));

   always_comb begin
      o_s    = sel ? {12'h000, s1} : s4;
      o_cout = sel ? cout1 : cout4;
      o_ovf  = sel ? ovf1  : ovf4;
      o_busy = sel ? busy1 : busy4;
      o_done = sel ? done1 : done4;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Reference: integer add/sub mod 2^w, no-borrow flag, signed range test.
   function automatic void model(input int w, input logic [15:0] av, bv, input logic ci, sb,
                                 output logic [15:0] rs, output logic rc, ro);
      longint m  = longint'(1) << w;
      longint ua = longint'(av), ub = longint'(bv), c = longint'(ci);
      longint r, sa, sbv, sr;
      r   = sb ? ua - ub - c : ua + ub + c;
      rs  = 16'(r & (m - 1));
      rc  = sb ? (r >= 0) : (r >= m);
      sa  = (ua >= m / 2) ? ua - m : ua;
      sbv = (ub >= m / 2) ? ub - m : ub;
      sr  = sb ? sa - sbv - c : sa + sbv + c;
      ro  = (sr >= m / 2) || (sr < -(m / 2));
   endfunction

   task automatic run_op(input int n, input logic [15:0] av, bv, input logic ci, sb,
                         input int glitch);
      logic [15:0] es, mask;
      logic        ec, eo;
      int          cyc;
      mask = (n == 1) ? 16'h000F : 16'hFFFF;
      model(4 * n, av & mask, bv & mask, ci, sb, es, ec, eo);
      sel = (n == 1);
      @(negedge clk);
      a = av; b = bv; c_in = ci; sub = sb;
      if (n == 1) start1 = 1'b1; else start4 = 1'b1;
      @(negedge clk);
      start1 = 1'b0; start4 = 1'b0;
      a = 16'($urandom); b = 16'($urandom); c_in = 1'($urandom); sub = 1'($urandom);
      cyc = 0;
      while (!o_done && cyc < 20) begin
         chk("busy_run", 32'(o_busy), 32'd1);
         start1 = 1'b0; start4 = 1'b0;
         if (cyc == glitch) begin
            a = 16'($urandom); b = 16'($urandom);
            if (n == 1) start1 = 1'b1; else start4 = 1'b1;
         end
         @(negedge clk);
         cyc++;
      end
      start1 = 1'b0; start4 = 1'b0;
      chk("latency", 32'(cyc), 32'(n));
      chk("busy_done", 32'(o_busy), 32'd1);
      chk("s", 32'(o_s), 32'(es));
      chk("c_out", 32'(o_cout), 32'(ec));
      chk("ovf", 32'(o_ovf), 32'(eo));
      @(negedge clk);
      chk("done_clr", 32'(o_done), 32'd0);
      chk("busy_clr", 32'(o_busy), 32'd0);
      chk("s_hold", 32'(o_s), 32'(es));
   endtask

   initial begin
      rst = 1'b1; start4 = 1'b1; start1 = 1'b1; sub = 1'b0; c_in = 1'b1;
      a = 16'h1111; b = 16'h2222; sel = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_s4", 32'(s4), 32'd0);
      chk("rst_flags4", {28'd0, cout4, ovf4, busy4, done4}, 32'd0);
      chk("rst_s1", 32'(s1), 32'd0);
      chk("rst_flags1", {28'd0, cout1, ovf1, busy1, done1}, 32'd0);
      rst = 1'b0; start4 = 1'b0; start1 = 1'b0;
      @(negedge clk);
      chk("idle_after_rst", {30'd0, busy4, busy1}, 32'd0);

      run_op(4, 16'h1234, 16'h0FF1, 1'b1, 1'b0, -1);
      run_op(4, 16'hFFFF, 16'h0001, 1'b0, 1'b0, -1);
      run_op(4, 16'h7FFF, 16'h0001, 1'b0, 1'b0, -1);
      run_op(4, 16'h0005, 16'h0007, 1'b0, 1'b1, -1);
      run_op(4, 16'h0007, 16'h0005, 1'b0, 1'b1, -1);
      run_op(4, 16'hABCD, 16'h1357, 1'b1, 1'b0, 1);

      // Abort mid-operation with reset.
      sel = 1'b0;
      @(negedge clk);
      a = 16'h4321; b = 16'h1111; sub = 1'b0; c_in = 1'b0; start4 = 1'b1;
      @(negedge clk);
      start4 = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("abort_busy", 32'(busy4), 32'd0);
      chk("abort_out", {11'd0, s4, cout4, ovf4, done4}, 32'd0);
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         chk("abort_nodone", 32'(done4), 32'd0);
      end
      run_op(4, 16'h0001, 16'h0001, 1'b0, 1'b0, -1);

      run_op(1, 16'h000A, 16'h000B, 1'b1, 1'b0, -1);
      run_op(1, 16'h0009, 16'h0004, 1'b0, 1'b0, -1);

      for (int i = 0; i < 25; i++)
         run_op(4, 16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom),
                int'($urandom_range(0, 4)) - 1);
      for (int i = 0; i < 25; i++)
         run_op(1, 16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom), -1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
